// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared constants for the dual-clock FIFO slice: default geometry and the
// depth of the Gray-pointer synchronizer chains.
// No ports (package).
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 10;

    // Two flops per crossing: enough MTBF for the FT245 clock rates while
    // keeping flag latency at 2 sync edges + 1 flag register edge.
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/async_fifo_gray_sync.sv
// -----------------------------------------------------------------------------
// async_fifo_gray_sync
// Multi-flop synchronizer for a Gray-coded pointer entering the clk domain.
// Because only one bit of a Gray pointer changes per increment, sampling all
// bits independently yields either the old or the new value, never a mix.
//
// Ports:
//   clk      in   destination-domain clock
//   rst      in   synchronous active-high reset (clears the chain to 0)
//   gray_in  in   WIDTH-bit Gray pointer from the source domain
//   gray_out out  WIDTH-bit pointer after SYNC_STAGES flops
// -----------------------------------------------------------------------------
module async_fifo_gray_sync
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_ADDRESS_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_out
);

    logic [WIDTH-1:0] stage_reg [SYNC_STAGES];

    // First stage is the metastability catcher.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg[0] <= '0;
        end else begin
            stage_reg[0] <= gray_in;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg[gi] <= '0;
                end else begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign gray_out = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo
// Dual-clock FIFO for moving byte/word streams between unrelated clock
// domains (FT245 host link: one side of it runs on ftdi_clk).
// Binary read/write pointers are ADDRESS_WIDTH+1 bits; each has a registered
// Gray mirror that crosses to the other domain through a two-flop
// synchronizer. Flags are registered from the next-pointer compare, so they
// assert on the edge of the operation that causes them and deassert late
// (never early) when the other side moves.
//
// Ports:
//   din_clk   in   write-domain clock
//   dout_clk  in   read-domain clock
//   rst       in   synchronous active-high reset, sampled in both domains
//   data_in   in   write data (DATA_WIDTH)
//   wr_en     in   write strobe (din_clk)
//   full      out  no free slot (din_clk domain, registered)
//   data_out  out  read data, registered (dout_clk domain)
//   rd_en     in   read strobe (dout_clk)
//   empty     out  no valid word (dout_clk domain, registered)
// -----------------------------------------------------------------------------
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                  din_clk,
    input  logic                  dout_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rd_en,
    output logic                  empty
);

    localparam int unsigned PTR_WIDTH = ADDRESS_WIDTH + 1;
    localparam int unsigned DEPTH     = 1 << ADDRESS_WIDTH;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    // A full FIFO has the write pointer exactly one lap ahead of the read
    // pointer. In Gray code that is the read pointer with its two MSBs flipped.
    localparam ptr_t FULL_MASK = ptr_t'(3) << (ADDRESS_WIDTH - 1);

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Storage: plain dual-port array, no reset, registered read.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write domain (din_clk)
    // ------------------------------------------------------------------
    ptr_t wbin_reg;
    ptr_t wbin_next;
    ptr_t wgray_reg;
    ptr_t wgray_next;
    ptr_t rgray_sync;
    logic full_reg;
    logic full_next;
    logic wr_accept;

    assign wr_accept  = wr_en && !full_reg;
    assign wbin_next  = wbin_reg + ptr_t'(wr_accept);
    assign wgray_next = bin2gray(wbin_next);
    // rgray_sync lags the true read pointer, so full can only stay up too
    // long, never drop early.
    assign full_next  = (wgray_next == (rgray_sync ^ FULL_MASK));

    always_ff @(posedge din_clk) begin
        if (rst) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
            full_reg  <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            wgray_reg <= wgray_next;
            full_reg  <= full_next;
        end
    end

    always_ff @(posedge din_clk) begin
        if (!rst && wr_accept) begin
            mem[wbin_reg[ADDRESS_WIDTH-1:0]] <= data_in;
        end
    end

    assign full = full_reg;

    // ------------------------------------------------------------------
    // Read domain (dout_clk)
    // ------------------------------------------------------------------
    ptr_t rbin_reg;
    ptr_t rbin_next;
    ptr_t rgray_reg;
    ptr_t rgray_next;
    ptr_t wgray_sync;
    logic empty_reg;
    logic empty_next;
    logic rd_accept;
    logic [DATA_WIDTH-1:0] data_out_reg;

    assign rd_accept  = rd_en && !empty_reg;
    assign rbin_next  = rbin_reg + ptr_t'(rd_accept);
    assign rgray_next = bin2gray(rbin_next);
    // wgray_sync lags the true write pointer, so empty can only stay up too
    // long, never drop early.
    assign empty_next = (rgray_next == wgray_sync);

    always_ff @(posedge dout_clk) begin
        if (rst) begin
            rbin_reg  <= '0;
            rgray_reg <= '0;
            empty_reg <= 1'b1;
        end else begin
            rbin_reg  <= rbin_next;
            rgray_reg <= rgray_next;
            empty_reg <= empty_next;
        end
    end

    // Output register holds its value until the next accepted read.
    always_ff @(posedge dout_clk) begin
        if (rst) begin
            data_out_reg <= '0;
        end else if (rd_accept) begin
            data_out_reg <= mem[rbin_reg[ADDRESS_WIDTH-1:0]];
        end
    end

    assign data_out = data_out_reg;
    assign empty    = empty_reg;

    // ------------------------------------------------------------------
    // Pointer crossings
    // ------------------------------------------------------------------
    async_fifo_gray_sync #(
        .WIDTH (PTR_WIDTH)
    ) u_wptr_sync (
        .clk      (dout_clk),
        .rst      (rst),
        .gray_in  (wgray_reg),
        .gray_out (wgray_sync)
    );

    async_fifo_gray_sync #(
        .WIDTH (PTR_WIDTH)
    ) u_rptr_sync (
        .clk      (din_clk),
        .rst      (rst),
        .gray_in  (rgray_reg),
        .gray_out (rgray_sync)
    );

endmodule

// File: tb/tb_async_fifo.sv
// -----------------------------------------------------------------------------
// tb_async_fifo
// Directed bench for async_fifo at DATA_WIDTH=8, ADDRESS_WIDTH=4 (depth 16),
// din_clk period 10, dout_clk period 16.
// -----------------------------------------------------------------------------
module tb_async_fifo;

    logic       din_clk  = 1'b0;
    logic       dout_clk = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] data_in  = 8'h00;
    logic       wr_en    = 1'b0;
    logic       rd_en    = 1'b0;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;
    int wr_seq;
    int rd_seq;
    logic stop_writer;

    async_fifo #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (4)
    ) dut (
        .din_clk  (din_clk),
        .dout_clk (dout_clk),
        .rst      (rst),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .full     (full),
        .data_out (data_out),
        .rd_en    (rd_en),
        .empty    (empty)
    );

    always #5 din_clk  = ~din_clk;
    always #8 dout_clk = ~dout_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        @(negedge din_clk);
        wr_en   = 1'b1;
        data_in = d;
        @(posedge din_clk);
        #1;
        wr_en = 1'b0;
        $display("write data=0x%02h full=%0b", d, full);
    endtask

    task automatic read_word();
        @(negedge dout_clk);
        rd_en = 1'b1;
        @(posedge dout_clk);
        #1;
        rd_en = 1'b0;
        $display("read  data_out=0x%02h empty=%0b", data_out, empty);
    endtask

    task automatic dout_wait(input int n);
        repeat (n) @(posedge dout_clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge dout_clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (5) @(negedge dout_clk);
        rst = 1'b0;
        dout_wait(1);
        $display("reset empty=%0b full=%0b data_out=0x%02h", empty, full, data_out);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        apply_reset();
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_dout", data_out, 0);
        read_word();
        read_word();
        chk("rd_on_empty_dout", data_out, 0);
        chk("rd_on_empty_empty", empty, 1);

        // ---------------- single word ----------------
        write_word(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(posedge dout_clk);
            #1;
            if (!empty) break;
        end
        chk("a5_empty_fall", empty, 0);
        read_word();
        chk("a5_data", data_out, 8'hA5);
        chk("a5_empty_rise", empty, 1);

        // ---------------- fill to capacity ----------------
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i));
            chk("fill_full", full, (i == 15) ? 1 : 0);
        end
        write_word(8'hFF);
        chk("drop_full", full, 1);
        dout_wait(4);
        read_word();
        chk("fill_data", data_out, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge din_clk);
            #1;
            if (!full) break;
        end
        chk("full_fall", full, 0);
        for (int i = 1; i < 16; i++) begin
            read_word();
            chk("fill_data", data_out, 8'(i));
        end
        chk("fill_empty_after", empty, 1);

        // ---------------- wrap: random strobes, 3x depth ----------------
        wr_seq = 0;
        rd_seq = 0;
        fork
            begin
                for (int c = 0; c < 4000 && wr_seq < 48; c++) begin
                    @(negedge din_clk);
                    wr_en   = 1'($urandom_range(0, 1));
                    data_in = 8'(8'h20 + wr_seq);
                    if (wr_en && !full) wr_seq++;
                end
                @(negedge din_clk);
                wr_en = 1'b0;
            end
            begin
                for (int c = 0; c < 4000 && rd_seq < 48; c++) begin
                    @(negedge dout_clk);
                    rd_en = 1'($urandom_range(0, 1));
                    if (rd_en && !empty) begin
                        @(posedge dout_clk);
                        #1;
                        $display("wrap read %0d data_out=0x%02h", rd_seq, data_out);
                        chk("wrap_data", data_out, 8'(8'h20 + rd_seq));
                        rd_seq++;
                    end
                end
                @(negedge dout_clk);
                rd_en = 1'b0;
            end
        join
        chk("wrap_wr_count", wr_seq, 48);
        chk("wrap_rd_count", rd_seq, 48);
        dout_wait(4);
        chk("wrap_empty", empty, 1);

        // ---------------- simultaneous read/write from half full ----------------
        for (int i = 0; i < 8; i++) write_word(8'(8'h80 + i));
        wr_seq = 8;
        rd_seq = 0;
        stop_writer = 1'b0;
        dout_wait(4);
        fork
            begin
                for (int c = 0; c < 1000 && !stop_writer; c++) begin
                    @(negedge din_clk);
                    wr_en   = 1'b1;
                    data_in = 8'(8'h80 + wr_seq);
                    if (!full) wr_seq++;
                end
                @(negedge din_clk);
                wr_en = 1'b0;
            end
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge dout_clk);
                    chk("sim_no_empty", empty, 0);
                    rd_en = 1'b1;
                    @(posedge dout_clk);
                    #1;
                    $display("sim read %0d data_out=0x%02h", rd_seq, data_out);
                    chk("sim_data", data_out, 8'(8'h80 + rd_seq));
                    rd_seq++;
                end
                @(negedge dout_clk);
                rd_en = 1'b0;
                stop_writer = 1'b1;
            end
        join
        dout_wait(4);
        for (int c = 0; c < 40; c++) begin
            if (empty) break;
            read_word();
            chk("drain_data", data_out, 8'(8'h80 + rd_seq));
            rd_seq++;
        end
        chk("drain_count", rd_seq, wr_seq);
        chk("drain_empty", empty, 1);

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 5; i++) write_word(8'(8'h50 + i));
        dout_wait(4);
        chk("pre_rst_empty", empty, 0);
        apply_reset();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_dout", data_out, 0);
        write_word(8'h3C);
        dout_wait(4);
        chk("rst_3c_ready", empty, 0);
        read_word();
        chk("rst_3c_data", data_out, 8'h3C);
        chk("rst_3c_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
